buzz_arb: RTL

BUZZ_ARB -- requirements
Module: buzz_arb

---
 rtl/buzz_arb.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/buzz_arb.sv
// Buzzer arbiter: alarm > chime > key, ms-tick timed tones on one shared NCO.
// Optional snooze hold-off when BUZZ_ARB_SNOOZE_EN is defined.
module buzz_arb #(
  parameter int TICK_DIV  = 50000,
  parameter int KEY_MS    = 100,
  parameter int CHIME_MS  = 200,
  parameter int ALARM_MS  = 500,
  parameter int GAP_MS    = 10,
  parameter int SNOOZE_MS = 5000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_key_req,
  input  logic        i_chime_req,
  input  logic        i_alarm_req,
  input  logic        i_snooze,
  output logic [31:0] o_nco_num,
  output logic        o_buzz_en,
  output logic [2:0]  o_grant,
  output logic        o_busy
);

  typedef enum logic [2:0] {
    IDLE, KEY, CHIME1, CHIME2, ALM_ON, ALM_OFF, GAP
`ifdef BUZZ_ARB_SNOOZE_EN
    , SNOOZE
`endif
  } state_t;

  state_t      state, nxt;
  logic [31:0] tick_cnt, ms_cnt, dur;
  logic        tick, done;
  logic        key_pend, chime_pend, key_pend_nxt, chime_pend_nxt;
  logic        key_now, chime_now, alarm_state;

`ifndef BUZZ_ARB_SNOOZE_EN
  logic unused_snooze;
  assign unused_snooze = i_snooze;
`endif

  assign key_now   = i_key_req | key_pend;
  assign chime_now = i_chime_req | chime_pend;
  assign tick      = (tick_cnt == 32'(TICK_DIV - 1));
  assign done      = tick && (ms_cnt == dur - 32'd1);
  assign alarm_state = (state == ALM_ON) || (state == ALM_OFF)
`ifdef BUZZ_ARB_SNOOZE_EN
                       || (state == SNOOZE)
`endif
                       ;

  always_comb begin
    dur = 32'd1;
    case (state)
      KEY:             dur = 32'(KEY_MS);
      CHIME1, CHIME2:  dur = 32'(CHIME_MS);
      ALM_ON, ALM_OFF: dur = 32'(ALARM_MS);
      GAP:             dur = 32'(GAP_MS);
`ifdef BUZZ_ARB_SNOOZE_EN
      SNOOZE:          dur = 32'(SNOOZE_MS);
`endif
      default:         dur = 32'd1;
    endcase
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE: begin
        if (i_alarm_req)    nxt = ALM_ON;
        else if (chime_now) nxt = CHIME1;
        else if (key_now)   nxt = KEY;
      end
      KEY: begin
        if (i_alarm_req) nxt = ALM_ON;
        else if (done)   nxt = GAP;
      end
      CHIME1: begin
        if (i_alarm_req) nxt = ALM_ON;
        else if (done)   nxt = CHIME2;
      end
      CHIME2: begin
        if (i_alarm_req) nxt = ALM_ON;
        else if (done)   nxt = GAP;
      end
      GAP: begin
        if (i_alarm_req) nxt = ALM_ON;
        else if (done) begin
          if (chime_now)    nxt = CHIME1;
          else if (key_now) nxt = KEY;
          else              nxt = IDLE;
        end
      end
      ALM_ON: begin
        if (!i_alarm_req) nxt = GAP;
`ifdef BUZZ_ARB_SNOOZE_EN
        else if (i_snooze) nxt = SNOOZE;
`endif
        else if (done)    nxt = ALM_OFF;
      end
      ALM_OFF: begin
        if (!i_alarm_req) nxt = GAP;
`ifdef BUZZ_ARB_SNOOZE_EN
        else if (i_snooze) nxt = SNOOZE;
`endif
        else if (done)    nxt = ALM_ON;
      end
`ifdef BUZZ_ARB_SNOOZE_EN
      SNOOZE: begin
        if (!i_alarm_req) nxt = IDLE;
        else if (done)    nxt = ALM_ON;
      end
`endif
      default: nxt = IDLE;
    endcase
  end

  // Pending flags: wiped on alarm entry, frozen during alarm, consumed on grant.
  always_comb begin
    key_pend_nxt   = key_pend;
    chime_pend_nxt = chime_pend;
    if (nxt == ALM_ON && !alarm_state) begin
      key_pend_nxt   = 1'b0;
      chime_pend_nxt = 1'b0;
    end else if (alarm_state) begin
      key_pend_nxt   = key_pend;
      chime_pend_nxt = chime_pend;
    end else if (nxt == CHIME1 && state != CHIME1) begin
      chime_pend_nxt = 1'b0;
      key_pend_nxt   = key_now;
    end else if (nxt == KEY && state != KEY) begin
      key_pend_nxt   = 1'b0;
      chime_pend_nxt = chime_now;
    end else begin
      key_pend_nxt   = key_now;
      chime_pend_nxt = chime_now;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      key_pend   <= 1'b0;
      chime_pend <= 1'b0;
    end else begin
      state      <= nxt;
      key_pend   <= key_pend_nxt;
      chime_pend <= chime_pend_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || nxt != state || state == IDLE) begin
      tick_cnt <= 32'd0;
      ms_cnt   <= 32'd0;
    end else if (tick) begin
      tick_cnt <= 32'd0;
      ms_cnt   <= ms_cnt + 32'd1;
    end else begin
      tick_cnt <= tick_cnt + 32'd1;
    end
  end

  // Outputs are registered from the next state so they align with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_nco_num <= 32'd0;
      o_buzz_en <= 1'b0;
      o_grant   <= 3'b000;
      o_busy    <= 1'b0;
    end else begin
      o_busy <= (nxt != IDLE);
      case (nxt)
        KEY:     begin o_nco_num <= 32'd191113; o_buzz_en <= 1'b1; o_grant <= 3'b001; end
        CHIME1:  begin o_nco_num <= 32'd63776;  o_buzz_en <= 1'b1; o_grant <= 3'b010; end
        CHIME2:  begin o_nco_num <= 32'd151686; o_buzz_en <= 1'b1; o_grant <= 3'b010; end
        ALM_ON:  begin o_nco_num <= 32'd56818;  o_buzz_en <= 1'b1; o_grant <= 3'b100; end
        ALM_OFF: begin o_nco_num <= 32'd0;      o_buzz_en <= 1'b0; o_grant <= 3'b100; end
        GAP:     begin o_nco_num <= 32'd0;      o_buzz_en <= 1'b0; end
        default: begin o_nco_num <= 32'd0;      o_buzz_en <= 1'b0; o_grant <= 3'b000; end
      endcase
    end
  end

endmodule
